// File: rtl/cskip_pkg.sv
// Shared definitions for the pipelined carry-skip adder/subtractor:
// default geometry, stage-count helper and the parameter legality check.
package cskip_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_GROUP = 4;

  // Number of carry-skip groups, which is also the number of pipeline stages.
  function automatic int calc_ng(input int width, input int group);
    return (group >= 1) ? (width / group) : 1;
  endfunction

  // Legal geometry: non-empty groups that tile the operand exactly.
  function automatic bit params_ok(input int width, input int group);
    if (group < 1) return 1'b0;
    if (width < group) return 1'b0;
    return (width % group) == 0;
  endfunction

endpackage

// File: rtl/cskip_group.sv
// One carry-skip group: GROUP-bit ripple adder whose carry out bypasses the
// ripple chain when every bit position propagates. Purely combinational.
module cskip_group
  import cskip_pkg::*;
#(
  parameter int GROUP = DEF_GROUP
) (
  input  logic [GROUP-1:0] a_g,
  input  logic [GROUP-1:0] b_g,
  input  logic             c_in,
  output logic [GROUP-1:0] s_g,
  output logic             c_out
);

  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;

  assign p = a_g ^ b_g;

  // Ripple carry chain through the group.
  always_comb begin
    // NOTE: assign the whole vector first so no bit is left unassigned on
    // any path; a partially written always_comb variable infers a latch.
    c    = '0;
    c[0] = c_in;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = (a_g[i] & b_g[i]) | (p[i] & c[i]);
    end
  end

  assign s_g = p ^ c[GROUP-1:0];

  // Skip mux: when all bits propagate, the ripple result equals c_in anyway,
  // so selecting c_in directly keeps results identical to a plain ripple adder.
  assign c_out = (&p) ? c_in : c[GROUP];

endmodule

// File: rtl/cskip_adder_pipe.sv
// Pipelined carry-skip adder/subtractor, one pipeline stage per GROUP-bit group.
// Valid/ready on both sides; a single advance enable freezes the whole pipe.
// Optional feature: define CSKIP_OVF_EN to add the registered signed-overflow
// output ovf.
module cskip_adder_pipe
  import cskip_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSKIP_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NG = calc_ng(WIDTH, GROUP);

  if (!params_ok(WIDTH, GROUP)) begin : g_param_check
    $error("cskip_adder_pipe: WIDTH (%0d) must be a non-zero multiple of GROUP (%0d)",
           WIDTH, GROUP);
  end

  // Advance enable: the pipe moves whenever the output slot is empty or drained.
  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Subtraction is A + ~B + 1; cin is ignored in that mode.
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  assign b_eff = b ^ {WIDTH{sub}};
  assign c0    = sub | cin;

  // Stage registers and their next values.
  logic [WIDTH-1:0] a_q [NG];
  logic [WIDTH-1:0] b_q [NG];
  logic [WIDTH-1:0] s_q [NG];
  logic             c_q [NG];
  logic             v_q [NG];

  logic [WIDTH-1:0] a_d [NG];
  logic [WIDTH-1:0] b_d [NG];
  logic [WIDTH-1:0] s_d [NG];
  logic             c_d [NG];
  logic             v_d [NG];

`ifdef CSKIP_OVF_EN
  logic ovf_d;
  logic ovf_q;
`endif

  for (genvar k = 0; k < NG; k++) begin : g_stage
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] s_i;
    logic             c_i;
    logic             v_i;
    logic [GROUP-1:0] s_g;
    logic             c_g;
    logic [WIDTH-1:0] s_m;

    if (k == 0) begin : g_first
      assign a_i = a;
      assign b_i = b_eff;
      assign s_i = '0;
      assign c_i = c0;
      assign v_i = in_valid;
    end else begin : g_next
      assign a_i = a_q[k-1];
      assign b_i = b_q[k-1];
      assign s_i = s_q[k-1];
      assign c_i = c_q[k-1];
      assign v_i = v_q[k-1];
    end

    cskip_group #(.GROUP(GROUP)) u_group (
      .a_g  (a_i[k*GROUP +: GROUP]),
      .b_g  (b_i[k*GROUP +: GROUP]),
      .c_in (c_i),
      .s_g  (s_g),
      .c_out(c_g)
    );

    // Merge this group's sum bits into the partial sum carried down the pipe.
    always_comb begin
      s_m                    = s_i;
      s_m[k*GROUP +: GROUP]  = s_g;
    end

    assign a_d[k] = a_i;
    assign b_d[k] = b_i;
    assign s_d[k] = s_m;
    assign c_d[k] = c_g;
    assign v_d[k] = v_i;

`ifdef CSKIP_OVF_EN
    if (k == NG - 1) begin : g_ovf
      // Carry into the MSB recovered from the MSB sum bit, XORed with carry out.
      assign ovf_d = (s_g[GROUP-1] ^ a_i[WIDTH-1] ^ b_i[WIDTH-1]) ^ c_g;
    end
`endif
  end

  // Pipeline registers: every stage shifts together on en, all clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
    end else if (en) begin
      // NOTE: non-blocking assignments so every stage samples the values its
      // predecessor held before this edge, regardless of loop order.
      for (int k = 0; k < NG; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
    end
  end

`ifdef CSKIP_OVF_EN
  // Signed overflow is captured alongside the final sum stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign out_valid = v_q[NG-1];
  assign sum       = s_q[NG-1];
  assign cout      = c_q[NG-1];

endmodule
